// File: rtl/fpga_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpga_cfg_loader_pkg
// Brief  : Shared header layout, region codes, FSM states and derived
//          configuration widths for the island-fabric configuration loader.
// Rev    : 1.0  initial release
// ============================================================================
package fpga_cfg_loader_pkg;

  // Header word layout (32-bit words)
  localparam logic [3:0] MAGIC          = 4'hA;
  localparam int         HDR_MAGIC_LSB  = 28;
  localparam int         HDR_REGION_LSB = 25;
  localparam int         HDR_OFFSET_LSB = 12;
  localparam int         HDR_LEN_LSB    = 0;
  localparam int         OFFSET_W       = 13;
  localparam int         LEN_W          = 12;
  localparam int         NUM_REGIONS    = 7;

  typedef enum logic [2:0] {
    REG_BRB    = 3'd0,
    REG_BSB    = 3'd1,
    REG_LB     = 3'd2,
    REG_LEFT   = 3'd3,
    REG_RIGHT  = 3'd4,
    REG_TOP    = 3'd5,
    REG_BOTTOM = 3'd6,
    REG_COMMIT = 3'd7
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CHK    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Derived select-bus widths of the N x N, W-track fabric
  function automatic int brb_bits(input int n, input int w);
    return (n + 1) * (n + 1) * w * 12;
  endfunction

  function automatic int bsb_bits(input int n, input int w);
    return n * n * w * w * 12;
  endfunction

  function automatic int lb_bits(input int n);
    return n * n * 5;
  endfunction

  function automatic int io_bits(input int n, input int w);
    return (n + 1) * w * 2;
  endfunction

  // Number of payload words needed to cover a region (last word may be partial)
  function automatic int words_for(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_cfg_loader_region.sv
`default_nettype none
// ============================================================================
// Module : fpga_cfg_loader_region
// Brief  : Shadow + live register pair for one configuration region. Words
//          land in the shadow copy; commit copies shadow to live, restore
//          copies live back into shadow.
// Rev    : 1.0  initial release
// ============================================================================
module fpga_cfg_loader_region
  import fpga_cfg_loader_pkg::*;
#(
  parameter int BITS   = 30,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [OFFSET_W-1:0] i_wr_idx,
  input  logic [WORD_W-1:0]   i_wr_data,
  input  logic                i_commit,
  input  logic                i_restore,
  output logic [BITS-1:0]     o_live
);

  logic [BITS-1:0] r_shadow;
  logic [BITS-1:0] r_live;

  // Shadow update: restore wins over a word write; bits past BITS are simply never addressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_restore) begin
      r_shadow <= r_live;
    end else if (i_wr_en) begin
      for (int b = 0; b < BITS; b++) begin
        if (i_wr_idx == OFFSET_W'(b / WORD_W)) begin
          r_shadow[b] <= i_wr_data[b % WORD_W];
        end
      end
    end
  end

  // Live copy only ever changes as a whole, on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
    end else if (i_commit) begin
      r_live <= r_shadow;
    end
  end

  assign o_live = r_live;

endmodule
`default_nettype wire

// File: rtl/fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : fpga_cfg_loader
// Brief  : Streaming configuration loader. Parses header/payload/checksum
//          packets from a valid/ready word stream into shadow registers and
//          atomically publishes all regions to the fabric on COMMIT.
// Rev    : 1.0  initial release
// ============================================================================
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 3,
  parameter int WORD_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        cfg_clr,
  output logic                        cfg_busy,
  output logic                        cfg_done,
  output logic                        cfg_err,
  output logic [brb_bits(N, W)-1:0]   brbselect,
  output logic [bsb_bits(N, W)-1:0]   bsbselect,
  output logic [lb_bits(N)-1:0]       lbselect,
  output logic [io_bits(N, W)-1:0]    leftioselect,
  output logic [io_bits(N, W)-1:0]    rightioselect,
  output logic [io_bits(N, W)-1:0]    topioselect,
  output logic [io_bits(N, W)-1:0]    bottomioselect
);

  localparam int BRB_BITS  = brb_bits(N, W);
  localparam int BSB_BITS  = bsb_bits(N, W);
  localparam int LB_BITS   = lb_bits(N);
  localparam int IO_BITS   = io_bits(N, W);
  localparam int BRB_WORDS = words_for(BRB_BITS, WORD_W);
  localparam int BSB_WORDS = words_for(BSB_BITS, WORD_W);
  localparam int LB_WORDS  = words_for(LB_BITS, WORD_W);
  localparam int IO_WORDS  = words_for(IO_BITS, WORD_W);

  state_e               r_state, w_state_nxt;
  logic [OFFSET_W-1:0]  r_ptr, w_ptr_nxt;
  logic [LEN_W-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]           r_region, w_region_nxt;
  logic [WORD_W-1:0]    r_csum, w_csum_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_done;
  logic                 r_started;

  logic                 w_xfer;
  logic                 w_commit;
  logic                 w_wr_any;
  logic [NUM_REGIONS-1:0] w_wr_en;

  // Header fields
  logic [3:0]           w_magic;
  region_e              w_region;
  logic [OFFSET_W-1:0]  w_off;
  logic [LEN_W-1:0]     w_len;
  logic [OFFSET_W:0]    w_end;
  logic [OFFSET_W:0]    w_limit;
  logic                 w_hdr_bad;

  assign w_magic  = in_data[HDR_MAGIC_LSB +: 4];
  assign w_region = region_e'(in_data[HDR_REGION_LSB +: 3]);
  assign w_off    = in_data[HDR_OFFSET_LSB +: OFFSET_W];
  assign w_len    = in_data[HDR_LEN_LSB +: LEN_W];
  assign w_end    = {1'b0, w_off} + {2'b00, w_len};

  // Ready depends only on state and clear so the source can never form a loop through us
  assign in_ready = r_started && !cfg_clr && (r_state != ST_COMMIT);
  assign w_xfer   = in_valid && in_ready;

  // Word capacity of the region addressed by the incoming header
  always_comb begin
    w_limit = '0;
    case (w_region)
      REG_BRB:                                  w_limit = (OFFSET_W + 1)'(BRB_WORDS);
      REG_BSB:                                  w_limit = (OFFSET_W + 1)'(BSB_WORDS);
      REG_LB:                                   w_limit = (OFFSET_W + 1)'(LB_WORDS);
      REG_LEFT, REG_RIGHT, REG_TOP, REG_BOTTOM: w_limit = (OFFSET_W + 1)'(IO_WORDS);
      default:                                  w_limit = '0;
    endcase
  end

  // COMMIT only needs a valid magic; data regions also need a non-empty, in-range window
  assign w_hdr_bad = (w_magic != MAGIC) ||
                     ((w_region != REG_COMMIT) && ((w_len == '0) || (w_end > w_limit)));

  // Next-state and datapath control; clear overrides everything else
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_region_nxt = r_region;
    w_csum_nxt   = r_csum;
    w_err_nxt    = r_err;
    w_commit     = 1'b0;
    w_wr_any     = 1'b0;
    if (cfg_clr) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_hdr_bad) begin
              w_err_nxt = 1'b1;
            end else if (w_region == REG_COMMIT) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              w_state_nxt  = ST_DATA;
              w_ptr_nxt    = w_off;
              w_cnt_nxt    = w_len;
              w_region_nxt = in_data[HDR_REGION_LSB +: 3];
              w_csum_nxt   = in_data;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            w_wr_any   = 1'b1;
            w_csum_nxt = r_csum ^ in_data;
            w_ptr_nxt  = r_ptr + OFFSET_W'(1);
            w_cnt_nxt  = r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              w_state_nxt = ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (w_xfer) begin
            if (in_data != r_csum) begin
              w_err_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
          end
        end
        ST_COMMIT: begin
          // A latched error keeps the fabric on its last good configuration
          w_commit    = !r_err;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Route the payload write strobe to the region selected by the current packet
  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_wr_en[i] = w_wr_any && (r_region == 3'(i));
    end
  end

  // FSM state, counters, checksum and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_region  <= '0;
      r_csum    <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_region  <= w_region_nxt;
      r_csum    <= w_csum_nxt;
      r_err     <= w_err_nxt;
      r_done    <= w_commit;
      r_started <= 1'b1;
    end
  end

  assign cfg_busy = (r_state != ST_IDLE);
  assign cfg_done = r_done;
  assign cfg_err  = r_err;

  fpga_cfg_loader_region #(.BITS(BRB_BITS), .WORD_W(WORD_W)) u_brb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en[REG_BRB]),
    .i_wr_idx  (r_ptr),
    .i_wr_data (in_data),
    .i_commit  (w_commit),
    .i_restore (cfg_clr),
    .o_live    (brbselect)
  );

  fpga_cfg_loader_region #(.BITS(BSB_BITS), .WORD_W(WORD_W)) u_bsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en[REG_BSB]),
    .i_wr_idx  (r_ptr),
    .i_wr_data (in_data),
    .i_commit  (w_commit),
    .i_restore (cfg_clr),
    .o_live    (bsbselect)
  );

  fpga_cfg_loader_region #(.BITS(LB_BITS), .WORD_W(WORD_W)) u_lb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en[REG_LB]),
    .i_wr_idx  (r_ptr),
    .i_wr_data (in_data),
    .i_commit  (w_commit),
    .i_restore (cfg_clr),
    .o_live    (lbselect)
  );

  // IO regions, in region-code order: left, right, top, bottom
  logic [IO_BITS-1:0] w_io_live [4];

  for (genvar k = 0; k < 4; k++) begin : g_io
    fpga_cfg_loader_region #(.BITS(IO_BITS), .WORD_W(WORD_W)) u_io (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[int'(REG_LEFT) + k]),
      .i_wr_idx  (r_ptr),
      .i_wr_data (in_data),
      .i_commit  (w_commit),
      .i_restore (cfg_clr),
      .o_live    (w_io_live[k])
    );
  end

  assign leftioselect   = w_io_live[0];
  assign rightioselect  = w_io_live[1];
  assign topioselect    = w_io_live[2];
  assign bottomioselect = w_io_live[3];

endmodule
`default_nettype wire

// File: tb/tb_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_fpga_cfg_loader
// Brief  : Self-checking bench for fpga_cfg_loader. A packet-level reference
//          model pushes expected live snapshots on each successful COMMIT;
//          a monitor pops one per cfg_done pulse and compares all buses.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fpga_cfg_loader;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          cfg_clr = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, cfg_busy, cfg_done, cfg_err;
  logic [899:0]  brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]   lbselect;
  logic [29:0]   leftioselect, rightioselect, topioselect, bottomioselect;

  always #5 clk = ~clk;

  fpga_cfg_loader #(.N(4), .W(3), .WORD_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .cfg_clr        (cfg_clr),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect)
  );

  int n_checks = 0;
  int n_err    = 0;
  int first_stall;

  int    RBITS [7] = '{900, 1728, 80, 30, 30, 30, 30};
  string BN    [7] = '{"brbselect", "bsbselect", "lbselect", "leftio", "rightio", "topio", "bottomio"};

  typedef struct { logic [1727:0] r [7]; } snap_t;
  snap_t exp_q[$];

  // Reference model: shadow/live images per region and the sticky error
  logic [1727:0] m_sh [7];
  logic [1727:0] m_lv [7];
  bit            m_err;

  function automatic int rwords(input int r);
    return (RBITS[r] + 31) / 32;
  endfunction

  function automatic logic [1727:0] dut_bus(input int r);
    case (r)
      0:       return 1728'(brbselect);
      1:       return bsbselect;
      2:       return 1728'(lbselect);
      3:       return 1728'(leftioselect);
      4:       return 1728'(rightioselect);
      5:       return 1728'(topioselect);
      default: return 1728'(bottomioselect);
    endcase
  endfunction

  task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [1727:0] act, input logic [1727:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      for (int k = 0; k < 54; k++) begin
        if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s word %0d got %h exp %h at %0t", nm, k, act[k*32 +: 32], exp[k*32 +: 32], $time);
          break;
        end
      end
    end
  endtask

  task automatic chk_all_live(input string tag);
    for (int r = 0; r < 7; r++) chk_bus({tag, "_", BN[r]}, dut_bus(r), m_lv[r]);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 7; r++) begin
      m_sh[r] = '0;
      m_lv[r] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_write(input int r, input int widx, input logic [31:0] d);
    for (int b = 0; b < 32; b++) begin
      if (widx * 32 + b < RBITS[r]) m_sh[r][widx * 32 + b] = d[b];
    end
  endtask

  // Whole-packet interpretation of the header / payload / checksum rules
  task automatic model_packet(input logic [31:0] pk[$]);
    logic [31:0] hdr, cs;
    int r, off, len;
    snap_t s;
    hdr = pk[0];
    r   = int'(hdr[27:25]);
    off = int'(hdr[24:12]);
    len = int'(hdr[11:0]);
    if (hdr[31:28] != 4'hA) begin
      m_err = 1'b1;
    end else if (r == 7) begin
      if (!m_err) begin
        for (int i = 0; i < 7; i++) begin
          m_lv[i]  = m_sh[i];
          s.r[i]   = m_sh[i];
        end
        exp_q.push_back(s);
      end
    end else if (len == 0 || off + len > rwords(r)) begin
      m_err = 1'b1;
    end else begin
      cs = hdr;
      for (int i = 0; i < len; i++) begin
        model_write(r, off + i, pk[1 + i]);
        cs ^= pk[1 + i];
      end
      if (pk[1 + len] != cs) m_err = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the word transferred
  task automatic send_word(input logic [31:0] d, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready) begin
      stalls++;
      if (stalls > 50) begin
        n_checks++;
        n_err++;
        $display("FAIL send_word timeout in_ready got 0 exp 1 word %h", d);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_packet(input logic [31:0] pk[$]);
    int st;
    for (int i = 0; i < pk.size(); i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send_word(pk[i], st);
      if (i == 0) first_stall = st;
    end
    in_valid = 1'b0;
    model_packet(pk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    cfg_clr  = 1'b1;
    #1;
    chk_val("in_ready_during_clr", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    cfg_clr = 1'b0;
    m_err   = 1'b0;
    for (int r = 0; r < 7; r++) m_sh[r] = m_lv[r];
  endtask

  task automatic commit_and_settle();
    send_packet('{32'hAE000000});
    idle(3);
  endtask

  // Scoreboard monitor: every cfg_done pulse must match the oldest expected snapshot
  always @(negedge clk) begin : mon
    snap_t s;
    if (rst_n && cfg_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL cfg_done unexpected pulse got 1 exp 0 at %0t", $time);
      end else begin
        s = exp_q.pop_front();
        for (int r = 0; r < 7; r++) chk_bus({"commit_", BN[r]}, dut_bus(r), s.r[r]);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] pk[$];
    logic [31:0] hdr, cs, w;
    int st, r, wr, off, len, op, kind;

    // ---- reset state ----
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_live("reset");
    chk_val("reset_busy", 64'(cfg_busy), 64'd0);
    chk_val("reset_done", 64'(cfg_done), 64'd0);
    chk_val("reset_err",  64'(cfg_err),  64'd0);
    rst_n = 1'b1;
    #1;
    chk_val("in_ready_first_cycle", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk_val("in_ready_after_reset", 64'(in_ready), 64'd1);

    // ---- XOR cell into lb cell 0 ----
    send_packet('{32'hA4000001, 32'h00000006, 32'hA4000007});
    chk_val("t2_err_after_data", 64'(cfg_err), 64'(m_err));
    commit_and_settle();
    chk_val("t2_lb_cell0", 64'(lbselect[4:0]), 64'h06);
    chk_val("t2_err", 64'(cfg_err), 64'd0);
    chk_val("t2_pending", 64'(exp_q.size()), 64'd0);

    // ---- out-of-range header blocks commit ----
    send_packet('{32'hA4002002});
    chk_val("t3_err", 64'(cfg_err), 64'd1);
    commit_and_settle();
    chk_bus("t3_lb_unchanged", 1728'(lbselect), m_lv[2]);
    chk_val("t3_pending", 64'(exp_q.size()), 64'd0);
    do_clr();

    // ---- bad checksum ----
    send_packet('{32'hA4000001, 32'h00000006, 32'h00000000});
    chk_val("t4_err", 64'(cfg_err), 64'd1);
    commit_and_settle();
    chk_bus("t4_lb_unchanged", 1728'(lbselect), m_lv[2]);
    do_clr();
    chk_val("t4_err_cleared", 64'(cfg_err), 64'd0);
    commit_and_settle();

    // ---- partial last word of lb ----
    send_packet('{32'hA4002001, 32'hFFFFFFFF, 32'h5BFFDFFE});
    commit_and_settle();
    chk_val("t5_lb_hi", 64'(lbselect[79:64]), 64'hFFFF);
    chk_val("t5_lb_lo", lbselect[63:0], 64'h6);

    // ---- clear mid-packet discards partial shadow writes ----
    send_word(32'hA4000002, st);
    send_word(32'h0000001F, st);
    in_valid = 1'b0;
    chk_val("clr_mid_busy", 64'(cfg_busy), 64'd1);
    do_clr();
    chk_val("clr_mid_busy_after", 64'(cfg_busy), 64'd0);
    commit_and_settle();

    // ---- valid held through COMMIT: exactly one stall, no word lost ----
    send_word(32'hAE000000, st);
    chk_val("t6_busy_in_commit", 64'(cfg_busy), 64'd1);
    model_packet('{32'hAE000000});
    send_word(32'hA4000001, st);
    chk_val("t6_commit_stall", 64'(st), 64'd1);
    send_word(32'h00000009, st);
    send_word(32'hA4000008, st);
    in_valid = 1'b0;
    model_packet('{32'hA4000001, 32'h00000009, 32'hA4000008});
    chk_val("t6_err", 64'(cfg_err), 64'(m_err));
    commit_and_settle();
    chk_val("t6_lb_cell0", 64'(lbselect[4:0]), 64'h09);

    // ---- reset in the middle of DATA ----
    send_word(32'hA4000003, st);
    send_word(32'h00001234, st);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    chk_all_live("midreset");
    chk_val("midreset_busy",  64'(cfg_busy), 64'd0);
    chk_val("midreset_done",  64'(cfg_done), 64'd0);
    chk_val("midreset_err",   64'(cfg_err),  64'd0);
    chk_val("midreset_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("postreset_ready", 64'(in_ready), 64'd1);
    send_packet('{32'hA4000001, 32'h00000015, 32'hA4000014});
    chk_val("postreset_err", 64'(cfg_err), 64'd0);
    commit_and_settle();

    // ---- randomized packet stream ----
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 99));
      pk = {};
      if (op < 10) begin
        do_clr();
      end else if (op < 25) begin
        send_packet('{32'hAE000000});
      end else if (op < 33) begin
        kind = int'($urandom_range(0, 2));
        r    = int'($urandom_range(0, 6));
        wr   = rwords(r);
        if (kind == 0) begin
          hdr = {4'($urandom_range(0, 9)), 28'($urandom)};
        end else if (kind == 1) begin
          off = int'($urandom_range(0, wr - 1));
          hdr = {4'hA, 3'(r), 13'(off), 12'h000};
        end else begin
          off = int'($urandom_range(0, wr));
          len = wr - off + 1 + int'($urandom_range(0, 3));
          hdr = {4'hA, 3'(r), 13'(off), 12'(len)};
        end
        pk.push_back(hdr);
        send_packet(pk);
      end else begin
        r   = int'($urandom_range(0, 6));
        wr  = rwords(r);
        off = int'($urandom_range(0, wr - 1));
        len = int'($urandom_range(1, (wr - off) < 12 ? (wr - off) : 12));
        hdr = {4'hA, 3'(r), 13'(off), 12'(len)};
        cs  = hdr;
        pk.push_back(hdr);
        for (int i = 0; i < len; i++) begin
          w = $urandom;
          pk.push_back(w);
          cs ^= w;
        end
        if ($urandom_range(0, 7) == 0) cs ^= (32'h1 << $urandom_range(0, 31));
        pk.push_back(cs);
        send_packet(pk);
      end
      chk_val("rand_err", 64'(cfg_err), 64'(m_err));
      idle(int'($urandom_range(0, 2)));
    end

    // ---- flush: clear, commit whatever shadow holds, verify everything drained ----
    do_clr();
    commit_and_settle();
    chk_all_live("final");
    chk_val("final_pending", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
